// File: rtl/acam_pkg.sv
// Shared types and constants for the ACAM TDC-GPX bus sequencer.
// Imported by the sequencer and its testbench.
package acam_pkg;

   localparam int c_ACAM_DATA_W = 28;
   localparam int c_ACAM_ADR_W  = 4;

   localparam logic [c_ACAM_ADR_W-1:0] c_FIFO1_ADR = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_DONE,
      S_RECOVER
   } t_acam_state;

endpackage

// File: rtl/gc_sync_ffs.sv
// Two-stage synchronizer for an asynchronous level input.
// Reset value is selectable so inactive-high flags start inactive.
module gc_sync_ffs #(
   parameter logic g_rst_val = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic data_i,
   output logic synced_o
);

   logic [1:0] sync_q;

   // shift the raw level through two flops
   always_ff @(posedge clk_i) begin
      if (rst_i) sync_q <= {2{g_rst_val}};
      else       sync_q <= {sync_q[0], data_i};
   end

   assign synced_o = sync_q[1];

endmodule

// File: rtl/acam_bus_sequencer.sv
// Owns the ACAM parallel bus: FIFO1 readout into a one-word
// timestamp buffer, arbitrated against host register accesses.
module acam_bus_sequencer
   import acam_pkg::*;
#(
   parameter int unsigned g_strobe_len = 4,
   parameter int unsigned g_recovery   = 2,
   parameter logic [c_ACAM_ADR_W-1:0] g_fifo1_adr = c_FIFO1_ADR
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     acq_en_i,
   input  logic                     acam_ef1_i,
   output logic [c_ACAM_ADR_W-1:0]  acam_adr_o,
   output logic                     acam_cs_n_o,
   output logic                     acam_rd_n_o,
   output logic                     acam_wr_n_o,
   input  logic [c_ACAM_DATA_W-1:0] acam_d_i,
   output logic [c_ACAM_DATA_W-1:0] acam_d_o,
   output logic                     acam_d_oe_o,
   input  logic                     host_req_i,
   input  logic                     host_we_i,
   input  logic [c_ACAM_ADR_W-1:0]  host_adr_i,
   input  logic [c_ACAM_DATA_W-1:0] host_wdata_i,
   output logic                     host_ack_o,
   output logic [c_ACAM_DATA_W-1:0] host_rdata_o,
   output logic                     ts_valid_o,
   output logic [c_ACAM_DATA_W-1:0] ts_data_o,
   input  logic                     ts_ready_i,
   output logic                     busy_o
);

   localparam logic [4:0] c_STB_LOAD = 5'(g_strobe_len - 1);
   localparam logic [4:0] c_REC_LOAD = 5'(g_recovery + 1);

   t_acam_state state, state_n;
   logic [4:0]  cnt, cnt_n;

   logic ef1_s;
   logic rd_pend, host_pend, grant_host;
   logic arb, grant, cap;

   logic                     host_q, we_q, last_host_q;
   logic [c_ACAM_ADR_W-1:0]  adr_q;
   logic [c_ACAM_DATA_W-1:0] wdata_q;
   logic                     ts_valid_q;
   logic [c_ACAM_DATA_W-1:0] ts_data_q, rdata_q;

   gc_sync_ffs #(
      .g_rst_val (1'b1)
   ) u_sync_ef1 (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .data_i   (acam_ef1_i),
      .synced_o (ef1_s)
   );

   assign rd_pend   = acq_en_i & ~ef1_s & ~ts_valid_q;
   assign host_pend = host_req_i;
   // on a tie, serve the side that was not served last
   assign grant_host = host_pend & (~rd_pend | ~last_host_q);

   // next state; the last RECOVER cycle arbitrates like IDLE
   // so back-to-back accesses need no extra idle cycle
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      arb     = 1'b0;
      grant   = 1'b0;
      unique case (state)
         S_IDLE: arb = 1'b1;
         S_SETUP: state_n = S_STROBE;
         S_STROBE: begin
            if (cnt == 5'd0) state_n = S_DONE;
            else             cnt_n   = cnt - 5'd1;
         end
         S_DONE: begin
            state_n = S_RECOVER;
            cnt_n   = c_REC_LOAD;
         end
         S_RECOVER: begin
            if (cnt == 5'd0) begin
               state_n = S_IDLE;
               arb     = 1'b1;
            end else begin
               cnt_n = cnt - 5'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (arb && (rd_pend || host_pend)) begin
         state_n = S_SETUP;
         cnt_n   = c_STB_LOAD;
         grant   = 1'b1;
      end
   end

   // state and strobe/recovery counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         cnt   <= 5'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // latch the granted access so the bus stays stable
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         host_q      <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         wdata_q     <= '0;
         last_host_q <= 1'b1;
      end else if (grant) begin
         host_q      <= grant_host;
         we_q        <= grant_host & host_we_i;
         adr_q       <= grant_host ? host_adr_i : g_fifo1_adr;
         last_host_q <= grant_host;
         if (grant_host && host_we_i) wdata_q <= host_wdata_i;
      end
   end

   assign cap = (state == S_STROBE) && (cnt == 5'd0);

   // single-entry timestamp buffer, filled on the last strobe
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts_valid_q <= 1'b0;
         ts_data_q  <= '0;
      end else if (cap && !host_q) begin
         ts_valid_q <= 1'b1;
         ts_data_q  <= acam_d_i;
      end else if (ts_valid_q && ts_ready_i) begin
         ts_valid_q <= 1'b0;
      end
   end

   // host read data, held until the next host read
   always_ff @(posedge clk_i) begin
      if (rst_i)                        rdata_q <= '0;
      else if (cap && host_q && !we_q)  rdata_q <= acam_d_i;
   end

   assign acam_adr_o  = adr_q;
   assign acam_d_o    = wdata_q;
   assign acam_cs_n_o = ~(state == S_STROBE);
   assign acam_rd_n_o = ~((state == S_STROBE) & ~we_q);
   assign acam_wr_n_o = ~((state == S_STROBE) & we_q);
   assign acam_d_oe_o = we_q & ((state == S_SETUP) |
                                (state == S_STROBE) |
                                (state == S_DONE));
   assign host_ack_o   = (state == S_DONE) & host_q;
   assign host_rdata_o = rdata_q;
   assign ts_valid_o   = ts_valid_q;
   assign ts_data_o    = ts_data_q;
   assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_acam_bus_sequencer.sv
// Directed bench for acam_bus_sequencer: vector table of single
// accesses plus contention, backpressure, reset and acq_en cases.
module tb_acam_bus_sequencer;
   import acam_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        acq_en_i = 1'b0;
   logic        acam_ef1_i = 1'b1;
   logic [3:0]  acam_adr_o;
   logic        acam_cs_n_o, acam_rd_n_o, acam_wr_n_o;
   logic [27:0] acam_d_i = '0;
   logic [27:0] acam_d_o;
   logic        acam_d_oe_o;
   logic        host_req_i = 1'b0;
   logic        host_we_i = 1'b0;
   logic [3:0]  host_adr_i = '0;
   logic [27:0] host_wdata_i = '0;
   logic        host_ack_o;
   logic [27:0] host_rdata_o;
   logic        ts_valid_o;
   logic [27:0] ts_data_o;
   logic        ts_ready_i = 1'b1;
   logic        busy_o;

   always #8 clk_i = ~clk_i;

   acam_bus_sequencer dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .acq_en_i     (acq_en_i),
      .acam_ef1_i   (acam_ef1_i),
      .acam_adr_o   (acam_adr_o),
      .acam_cs_n_o  (acam_cs_n_o),
      .acam_rd_n_o  (acam_rd_n_o),
      .acam_wr_n_o  (acam_wr_n_o),
      .acam_d_i     (acam_d_i),
      .acam_d_o     (acam_d_o),
      .acam_d_oe_o  (acam_d_oe_o),
      .host_req_i   (host_req_i),
      .host_we_i    (host_we_i),
      .host_adr_i   (host_adr_i),
      .host_wdata_i (host_wdata_i),
      .host_ack_o   (host_ack_o),
      .host_rdata_o (host_rdata_o),
      .ts_valid_o   (ts_valid_o),
      .ts_data_o    (ts_data_o),
      .ts_ready_i   (ts_ready_i),
      .busy_o       (busy_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  name, act, exp);
      end
   endtask

   // bus monitor, sampled on the falling edge
   int cyc = 0;
   int m_rd = 0, m_wr = 0, m_oe = 0;
   int m_ack = 0, m_val = 0, m_starts = 0;
   int m_adr_bad = 0, m_d_bad = 0;
   logic [3:0]  m_adr = '0;
   logic [27:0] m_d = '0;
   logic prev_cs = 1'b1, prev_oe = 1'b0;
   int         st_cyc[$];
   logic [3:0] st_adr[$];

   always @(negedge clk_i) begin
      cyc++;
      if (!acam_rd_n_o) m_rd++;
      if (!acam_wr_n_o) m_wr++;
      if (acam_d_oe_o)  m_oe++;
      if (host_ack_o)   m_ack++;
      if (ts_valid_o)   m_val++;
      if (!acam_cs_n_o && prev_cs) begin
         m_starts++;
         m_adr = acam_adr_o;
         st_cyc.push_back(cyc);
         st_adr.push_back(acam_adr_o);
      end else if (!acam_cs_n_o && acam_adr_o !== m_adr) begin
         m_adr_bad++;
      end
      if (acam_d_oe_o && !prev_oe) m_d = acam_d_o;
      else if (acam_d_oe_o && acam_d_o !== m_d) m_d_bad++;
      prev_cs = acam_cs_n_o;
      prev_oe = acam_d_oe_o;
   end

   typedef struct {
      bit          host;
      bit          we;
      logic [3:0]  adr;
      logic [27:0] wdata;
      logic [27:0] din;
      int          lat;
      logic [3:0]  e_adr;
      int          e_rd;
      int          e_wr;
      int          e_oe;
      int          e_ack;
      int          e_val;
      logic [27:0] e_data;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v, input int i);
      int r0, w0, o0, a0, va0, s0, ab0, db0, lat;
      bit done;
      logic [27:0] got;
      r0 = m_rd; w0 = m_wr; o0 = m_oe; a0 = m_ack;
      va0 = m_val; s0 = m_starts;
      ab0 = m_adr_bad; db0 = m_d_bad;
      acam_d_i = v.din;
      if (v.host) begin
         host_we_i    = v.we;
         host_adr_i   = v.adr;
         host_wdata_i = v.wdata;
         host_req_i   = 1'b1;
      end else begin
         ts_ready_i = 1'b1;
         acq_en_i   = 1'b1;
         acam_ef1_i = 1'b0;
      end
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_i);
         if (!acam_cs_n_o) begin
            lat = k;
            break;
         end
      end
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
      acam_ef1_i = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk_i);
         if (host_ack_o) host_req_i = 1'b0;
         if (!busy_o) begin
            done = 1'b1;
            break;
         end
      end
      host_req_i = 1'b0;
      acq_en_i   = 1'b0;
      chk($sformatf("v%0d done", i), 32'(done), 32'd1);
      repeat (3) @(negedge clk_i);
      chk($sformatf("v%0d starts", i), 32'(m_starts - s0), 32'd1);
      chk($sformatf("v%0d adr", i), 32'(m_adr), 32'(v.e_adr));
      chk($sformatf("v%0d rd_n low", i), 32'(m_rd - r0), 32'(v.e_rd));
      chk($sformatf("v%0d wr_n low", i), 32'(m_wr - w0), 32'(v.e_wr));
      chk($sformatf("v%0d oe cyc", i), 32'(m_oe - o0), 32'(v.e_oe));
      chk($sformatf("v%0d ack", i), 32'(m_ack - a0), 32'(v.e_ack));
      chk($sformatf("v%0d valid", i), 32'(m_val - va0), 32'(v.e_val));
      chk($sformatf("v%0d adr stable", i),
          32'(m_adr_bad - ab0), 32'd0);
      chk($sformatf("v%0d d stable", i),
          32'(m_d_bad - db0), 32'd0);
      if (v.host && v.we)  got = acam_d_o;
      else if (v.host)     got = host_rdata_o;
      else                 got = ts_data_o;
      chk($sformatf("v%0d data", i), 32'(got), 32'(v.e_data));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ns, s0, v0, a0, k1;
      bit hit;

      //        host we adr  wdata        din          lat adr
      //        rd wr oe ack val data
      vecs[0] = '{0, 0, 4'h0, 28'h0, 28'h0ABCDEF, 4, 4'h8,
                  4, 0, 0, 0, 1, 28'h0ABCDEF};
      vecs[1] = '{1, 1, 4'h5, 28'h1234567, 28'h0, 2, 4'h5,
                  0, 4, 6, 1, 0, 28'h1234567};
      vecs[2] = '{1, 0, 4'h3, 28'h0, 28'h5A5A5A5, 2, 4'h3,
                  4, 0, 0, 1, 0, 28'h5A5A5A5};
      vecs[3] = '{0, 0, 4'h0, 28'h0, 28'hFFFFFFF, 4, 4'h8,
                  4, 0, 0, 0, 1, 28'hFFFFFFF};
      vecs[4] = '{1, 1, 4'hF, 28'h0, 28'h7777777, 2, 4'hF,
                  0, 4, 6, 1, 0, 28'h0};

      repeat (3) @(negedge clk_i);
      chk("rst cs_n", 32'(acam_cs_n_o), 32'd1);
      chk("rst rd_n", 32'(acam_rd_n_o), 32'd1);
      chk("rst wr_n", 32'(acam_wr_n_o), 32'd1);
      chk("rst oe", 32'(acam_d_oe_o), 32'd0);
      chk("rst adr", 32'(acam_adr_o), 32'd0);
      chk("rst d_o", 32'(acam_d_o), 32'd0);
      chk("rst ts_valid", 32'(ts_valid_o), 32'd0);
      chk("rst ts_data", 32'(ts_data_o), 32'd0);
      chk("rst ack", 32'(host_ack_o), 32'd0);
      chk("rst rdata", 32'(host_rdata_o), 32'd0);
      chk("rst busy", 32'(busy_o), 32'd0);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
      chk("rdata held", 32'(host_rdata_o), 32'h5A5A5A5);

      // contention: readout wins the first tie after reset
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      acam_d_i   = 28'h0C0FFEE;
      host_we_i  = 1'b0;
      host_adr_i = 4'h2;
      ts_ready_i = 1'b1;
      acam_ef1_i = 1'b0;
      repeat (4) @(negedge clk_i);
      ns = st_cyc.size();
      acq_en_i   = 1'b1;
      host_req_i = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk_i);
         if (st_cyc.size() >= ns + 3) break;
      end
      acq_en_i   = 1'b0;
      host_req_i = 1'b0;
      acam_ef1_i = 1'b1;
      if (st_cyc.size() >= ns + 3) begin
         chk("cont 1st adr", 32'(st_adr[ns]), 32'h8);
         chk("cont 2nd adr", 32'(st_adr[ns+1]), 32'h2);
         chk("cont 3rd adr", 32'(st_adr[ns+2]), 32'h8);
         chk("cont gap 1", 32'(st_cyc[ns+1] - st_cyc[ns]), 32'd10);
         chk("cont gap 2", 32'(st_cyc[ns+2] - st_cyc[ns+1]), 32'd10);
      end else begin
         chk("cont starts", 32'(st_cyc.size() - ns), 32'd3);
      end
      repeat (30) @(negedge clk_i);
      chk("cont idle", 32'(busy_o), 32'd0);
      chk("cont rdata", 32'(host_rdata_o), 32'h0C0FFEE);
      chk("cont ts_data", 32'(ts_data_o), 32'h0C0FFEE);

      // backpressure: one read only while the word is unread
      ts_ready_i = 1'b0;
      acam_d_i   = 28'h2468ACE;
      s0 = m_starts;
      acq_en_i   = 1'b1;
      acam_ef1_i = 1'b0;
      repeat (40) @(negedge clk_i);
      chk("bp starts", 32'(m_starts - s0), 32'd1);
      chk("bp valid", 32'(ts_valid_o), 32'd1);
      chk("bp busy", 32'(busy_o), 32'd0);
      chk("bp data", 32'(ts_data_o), 32'h2468ACE);
      acam_d_i   = 28'h1111111;
      ts_ready_i = 1'b1;
      acq_en_i   = 1'b0;
      acam_ef1_i = 1'b1;
      @(negedge clk_i);
      chk("bp accepted", 32'(ts_valid_o), 32'd0);
      chk("bp data kept", 32'(ts_data_o), 32'h2468ACE);
      repeat (5) @(negedge clk_i);
      chk("bp no more rd", 32'(m_starts - s0), 32'd1);

      // reset on the second strobe cycle
      acam_d_i = 28'h0DEAD00;
      v0 = m_val;
      a0 = m_ack;
      acq_en_i   = 1'b1;
      acam_ef1_i = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_i);
         if (!acam_cs_n_o) begin
            hit = 1'b1;
            break;
         end
      end
      chk("rst strobe seen", 32'(hit), 32'd1);
      @(negedge clk_i);
      chk("rst 2nd strobe", 32'(acam_rd_n_o), 32'd0);
      rst_i      = 1'b1;
      acq_en_i   = 1'b0;
      acam_ef1_i = 1'b1;
      @(negedge clk_i);
      chk("mid rst cs_n", 32'(acam_cs_n_o), 32'd1);
      chk("mid rst rd_n", 32'(acam_rd_n_o), 32'd1);
      chk("mid rst wr_n", 32'(acam_wr_n_o), 32'd1);
      chk("mid rst busy", 32'(busy_o), 32'd0);
      chk("mid rst valid", 32'(ts_valid_o), 32'd0);
      chk("mid rst ack", 32'(host_ack_o), 32'd0);
      rst_i = 1'b0;
      repeat (12) @(negedge clk_i);
      chk("mid rst no valid", 32'(m_val - v0), 32'd0);
      chk("mid rst no ack", 32'(m_ack - a0), 32'd0);

      // acq_en dropped during the strobe
      acam_d_i   = 28'h1357246;
      ts_ready_i = 1'b1;
      s0 = m_starts;
      v0 = m_val;
      acq_en_i   = 1'b1;
      acam_ef1_i = 1'b0;
      k1 = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_i);
         if (!acam_rd_n_o) begin
            k1 = k;
            break;
         end
      end
      acq_en_i = 1'b0;
      chk("acq latency", 32'(k1), 32'd4);
      repeat (30) @(negedge clk_i);
      chk("acq delivered", 32'(m_val - v0), 32'd1);
      chk("acq data", 32'(ts_data_o), 32'h1357246);
      chk("acq one read", 32'(m_starts - s0), 32'd1);
      acam_ef1_i = 1'b1;
      repeat (3) @(negedge clk_i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
